// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg
// Shared definitions for the PWM capture block and its generator counterpart.
//   DVSR_DEFAULT : prescaler terminal count used by both ends of the link, so
//                  a generator/capture pair agree on the tick period.
//   DUTY_W       : width of the duty code.
//   cap_state_e  : capture FSM states.
//   sat_duty()   : clamps a high-time count to the duty code range.
package pwm_capture_pkg;

  localparam int DVSR_DEFAULT  = 10417;
  localparam int CNT_W_DEFAULT = 9;
  localparam int DUTY_W        = 8;
  localparam int unsigned DUTY_MAX = (2 ** DUTY_W) - 1;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    LOCKED,
    STUCK
  } cap_state_e;

  // Long high times (more than DUTY_MAX ticks) are reported as full scale.
  function automatic logic [DUTY_W-1:0] sat_duty(input int unsigned cnt);
    if (cnt > DUTY_MAX) begin
      return '1;
    end
    return DUTY_W'(cnt);
  endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// pwm_capture_if
// Result bus of the PWM capture block.
//   duty_o       : last measured duty code (high ticks, saturated)
//   period_o     : last measured period in ticks
//   duty_valid_o : one-clock strobe when duty_o/period_o update
//   locked_o     : successive rising edges are being measured
//   timeout_o    : input is stuck (no rising edge for the timeout window)
// The master modport is the capture block, the slave modport its consumer.
// CNT_W must match the CNT_W of the connected pwm_capture.
interface pwm_capture_if #(
  parameter int CNT_W = 9
);
  import pwm_capture_pkg::*;

  logic [DUTY_W-1:0] duty_o;
  logic [CNT_W-1:0]  period_o;
  logic              duty_valid_o;
  logic              locked_o;
  logic              timeout_o;

  modport master (
    output duty_o,
    output period_o,
    output duty_valid_o,
    output locked_o,
    output timeout_o
  );

  modport slave (
    input duty_o,
    input period_o,
    input duty_valid_o,
    input locked_o,
    input timeout_o
  );

endinterface

// File: rtl/pwm_capture_tick_prescaler.sv
// pwm_tick_prescaler
// Free-running divider: q counts 0..DVSR and wraps, tick_o is high while q==0,
// so one tick every DVSR+1 clocks. Never resynchronised to any input.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset (q returns to 0)
//   tick_o : one-clock tick
module pwm_tick_prescaler
  import pwm_capture_pkg::*;
#(
  parameter int DVSR = DVSR_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int Q_W = (DVSR > 0) ? $clog2(DVSR + 1) : 1;

  logic [Q_W-1:0] q_q;
  logic [Q_W-1:0] q_d;

  always_comb begin
    q_d = (q_q == Q_W'(DVSR)) ? '0 : q_q + Q_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign tick_o = (q_q == '0);

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture
// Measures an incoming PWM waveform: high ticks and period ticks between
// successive rising edges, sampled on the shared prescaler tick.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   pwm_i : asynchronous PWM input
//   cap   : result bus (duty_o, period_o, duty_valid_o, locked_o, timeout_o)
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int DVSR          = DVSR_DEFAULT,
  parameter int CNT_W         = CNT_W_DEFAULT,
  parameter int TIMEOUT_TICKS = 512
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pwm_i,
  pwm_capture_if.master cap
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_TICKS - 1);

  logic tick;

  pwm_tick_prescaler #(.DVSR(DVSR)) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );

  // Two-stage synchroniser (sync1_q, s_q) plus a delayed copy for edge detect.
  logic sync1_q, s_q, s_dly_q;
  logic rise;

  assign rise = s_q & ~s_dly_q;

  cap_state_e        state_q, state_d;
  logic [CNT_W-1:0]  hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              valid_q, valid_d;
  logic              locked_q, locked_d;
  logic              timeout_q, timeout_d;

  logic [CNT_W-1:0]  hi_inc, per_inc;
  logic              timeout_hit;

  always_comb begin
    hi_inc  = (hi_cnt_q == CNT_MAX) ? hi_cnt_q : hi_cnt_q + CNT_W'(s_q);
    per_inc = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + CNT_W'(1);
    // STUCK never re-reports; it only leaves on a rising edge.
    timeout_hit = tick && (per_cnt_q == TO_LAST) && (state_q != STUCK);

    state_d   = state_q;
    hi_cnt_d  = hi_cnt_q;
    per_cnt_d = per_cnt_q;
    duty_d    = duty_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;

    // A rising edge takes priority over a coincident tick: the counters
    // restart at 0 and that tick's increment (and any timeout) is dropped.
    if (rise) begin
      hi_cnt_d  = '0;
      per_cnt_d = '0;
      case (state_q)
        IDLE: begin
          state_d = ARMED;
        end
        ARMED, LOCKED: begin
          duty_d   = sat_duty(32'(hi_cnt_q));
          period_d = per_cnt_q;
          valid_d  = 1'b1;
          locked_d = 1'b1;
          state_d  = LOCKED;
        end
        STUCK: begin
          timeout_d = 1'b0;
          state_d   = ARMED;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else if (tick) begin
      hi_cnt_d  = hi_inc;
      per_cnt_d = per_inc;
      if (timeout_hit) begin
        // Report the level the input is stuck at as 0 or full scale.
        duty_d    = s_q ? '1 : '0;
        period_d  = '0;
        valid_d   = 1'b1;
        locked_d  = 1'b0;
        timeout_d = 1'b1;
        state_d   = STUCK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      s_q       <= 1'b0;
      s_dly_q   <= 1'b0;
      state_q   <= IDLE;
      hi_cnt_q  <= '0;
      per_cnt_q <= '0;
      duty_q    <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      sync1_q   <= pwm_i;
      s_q       <= sync1_q;
      s_dly_q   <= s_q;
      state_q   <= state_d;
      hi_cnt_q  <= hi_cnt_d;
      per_cnt_q <= per_cnt_d;
      duty_q    <= duty_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign cap.duty_o       = duty_q;
  assign cap.period_o     = period_q;
  assign cap.duty_valid_o = valid_q;
  assign cap.locked_o     = locked_q;
  assign cap.timeout_o    = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture
// Drives pwm_capture (DVSR=3, 4-clock tick) from a PWM generator model with a
// 256-tick period. Each generated rising edge that closes a full period pushes
// the expected measurement into a scoreboard queue; a monitor pops and checks
// on every duty_valid_o strobe.
module tb_pwm_capture;
  import pwm_capture_pkg::*;

  localparam int DVSR  = 3;
  localparam int TK    = DVSR + 1;
  localparam int CNT_W = 9;
  localparam int TO    = 512;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic pwm   = 1'b0;

  always #5 clk = ~clk;

  pwm_capture_if #(.CNT_W(CNT_W)) cap_if ();

  pwm_capture #(
    .DVSR          (DVSR),
    .CNT_W         (CNT_W),
    .TIMEOUT_TICKS (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pwm_i (pwm),
    .cap   (cap_if.master)
  );

  typedef struct {
    int    duty;
    int    dtol;
    int    period;
    int    ptol;
    int    locked;
    int    timeout;
    int    gap;
    string name;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_e;
  int     total = 0;
  int     bad   = 0;

  // cyc mirrors the prescaler phase: after posedge k, q == k % TK.
  int     cyc = 0;
  longint clk_cnt = 0;
  longint last_strobe = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(posedge clk) clk_cnt <= clk_cnt + 1;

  // Generator state
  int prev_duty      = -1;
  int strobes_in_run = 0;
  int phase          = 0;
  int exp_per        = 256;
  int per_tol        = 1;

  task automatic check_int(input string name, input int act, input int req, input int tol);
    total++;
    if (act < req - tol || act > req + tol) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (+/-%0d)", name, act, req, tol);
    end
  endtask

  task automatic push_exp(input int duty, input int dtol, input int period, input int ptol,
                          input int lk, input int to, input int gap, input string name);
    exp_t e;
    e.duty = duty; e.dtol = dtol; e.period = period; e.ptol = ptol;
    e.locked = lk; e.timeout = to; e.gap = gap; e.name = name;
    sb.push_back(e);
  endtask

  task automatic check_zero(input string name);
    check_int({name, ".duty"},    int'(cap_if.duty_o),       0, 0);
    check_int({name, ".period"},  int'(cap_if.period_o),     0, 0);
    check_int({name, ".valid"},   int'(cap_if.duty_valid_o), 0, 0);
    check_int({name, ".locked"},  int'(cap_if.locked_o),     0, 0);
    check_int({name, ".timeout"}, int'(cap_if.timeout_o),    0, 0);
  endtask

  // n full periods of duty/256 with a TK-clock tick; pwm_i changes on negedges.
  // Rise is launched when cyc % TK == phase: phase 0 keeps the DUT's rise
  // cycle off the tick, phase 2 lands it exactly on a tick.
  task automatic run_pwm(input int duty, input int n);
    for (int p = 0; p < n; p++) begin
      while ((cyc % TK) != phase) @(negedge clk);
      if (prev_duty >= 0) begin
        push_exp(prev_duty, 1, exp_per, per_tol, 1, 0,
                 (strobes_in_run > 0) ? 256 * TK : 0,
                 $sformatf("duty%0d", prev_duty));
        strobes_in_run++;
      end
      prev_duty = duty;
      pwm = 1'b1;
      repeat (TK * duty) @(negedge clk);
      pwm = 1'b0;
      repeat (TK * (256 - duty)) @(negedge clk);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && cap_if.duty_valid_o) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got duty=%0d period=%0d timeout=%0b, want no strobe",
                 cap_if.duty_o, cap_if.period_o, cap_if.timeout_o);
      end else begin
        mon_e = sb.pop_front();
        check_int({mon_e.name, ".duty"},    int'(cap_if.duty_o),    mon_e.duty,    mon_e.dtol);
        check_int({mon_e.name, ".period"},  int'(cap_if.period_o),  mon_e.period,  mon_e.ptol);
        check_int({mon_e.name, ".locked"},  int'(cap_if.locked_o),  mon_e.locked,  0);
        check_int({mon_e.name, ".timeout"}, int'(cap_if.timeout_o), mon_e.timeout, 0);
        if (mon_e.gap > 0)
          check_int({mon_e.name, ".gap"}, int'(clk_cnt - last_strobe), mon_e.gap, 0);
        $display("strobe %s: duty=%0d period=%0d locked=%0b timeout=%0b",
                 mon_e.name, cap_if.duty_o, cap_if.period_o, cap_if.locked_o, cap_if.timeout_o);
      end
      last_strobe = clk_cnt;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, want finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Lock onto duty 128: first rise arms, later rises strobe every 1024 clks
    run_pwm(128, 4);
    check_int("lock128.locked_o", int'(cap_if.locked_o), 1, 0);

    // Duty sweep with changes mid-run
    run_pwm(1, 2);
    run_pwm(64, 2);
    run_pwm(200, 2);
    run_pwm(255, 2);

    // Reset while LOCKED clears everything at once
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    check_int("midreset.queue", sb.size(), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_duty = -1;
    strobes_in_run = 0;

    // Input held low from reset: timeout on the 512th tick (posedge 2045)
    push_exp(0, 0, 0, 0, 0, 1, 0, "stuck_lo");
    repeat (2040) @(negedge clk);
    check_int("stuck_lo.early_timeout", int'(cap_if.timeout_o), 0, 0);
    repeat (10) @(negedge clk);
    check_int("stuck_lo.timeout_o", int'(cap_if.timeout_o), 1, 0);
    check_int("stuck_lo.duty_o",    int'(cap_if.duty_o),    0, 0);
    check_int("stuck_lo.period_o",  int'(cap_if.period_o),  0, 0);
    check_int("stuck_lo.locked_o",  int'(cap_if.locked_o),  0, 0);
    check_int("stuck_lo.queue",     sb.size(),              0, 0);
    repeat (1100) @(negedge clk);

    // Rise leaves STUCK; then held high times out with full-scale duty
    pwm = 1'b1;
    repeat (10) @(negedge clk);
    check_int("rise_clears.timeout_o", int'(cap_if.timeout_o), 0, 0);
    push_exp(255, 0, 0, 0, 0, 1, 0, "stuck_hi");
    repeat (2100) @(negedge clk);
    check_int("stuck_hi.timeout_o", int'(cap_if.timeout_o), 1, 0);
    check_int("stuck_hi.duty_o",    int'(cap_if.duty_o),    255, 0);
    check_int("stuck_hi.queue",     sb.size(),              0, 0);

    // Resume 128: timeout clears on first rise, lock one period later
    pwm = 1'b0;
    repeat (8) @(negedge clk);
    prev_duty = -1;
    strobes_in_run = 0;
    run_pwm(128, 1);
    check_int("resume.timeout_o", int'(cap_if.timeout_o), 0, 0);
    check_int("resume.armed_locked_o", int'(cap_if.locked_o), 0, 0);
    run_pwm(128, 2);
    check_int("resume.locked_o", int'(cap_if.locked_o), 1, 0);

    // Reset while LOCKED, then rises coincident with ticks: the dropped tick
    // makes every period measure exactly 255
    rst_n = 1'b0;
    #1;
    check_zero("reset_locked");
    @(negedge clk);
    rst_n = 1'b1;
    prev_duty = -1;
    strobes_in_run = 0;
    phase = 2;
    exp_per = 255;
    per_tol = 0;
    run_pwm(128, 3);
    repeat (20) @(negedge clk);

    check_int("drain.queue", sb.size(), 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
